// File: rtl/pcie_pio_pkg.sv
// pcie_pio_pkg: shared request types, completion status codes and CQ/CC descriptor layouts
package pcie_pio_pkg;
  typedef enum logic [3:0] {
    MEM_RD = 4'b0000,
    MEM_WR = 4'b0001
  } req_type_e;
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;
  localparam int DESC_ADDR_LSB = 2;
  localparam int DESC_LOWADDR_MSB = 6;
  localparam int DESC_FBE_W = 4;
  typedef struct packed {
    logic        rsvd63;
    logic [2:0]  attr;
    logic [2:0]  tc;
    logic [16:0] misc;
    logic [7:0]  tag;
    logic [15:0] requester_id;
    logic        rsvd15;
    logic [3:0]  req_type;
    logic [10:0] dw_count;
  } cq_desc1_t;
  typedef struct packed {
    logic [15:0] requester_id;
    logic [1:0]  rsvd47;
    logic [2:0]  status;
    logic [10:0] dw_count;
    logic [2:0]  rsvd31;
    logic [12:0] byte_count;
    logic [5:0]  rsvd15;
    logic [1:0]  at;
    logic        rsvd7;
    logic [6:0]  lower_addr;
  } cc_beat0_t;
  typedef struct packed {
    logic [31:0] data;
    logic        rsvd31;
    logic [2:0]  attr;
    logic [2:0]  tc;
    logic        cid_en;
    logic [15:0] completer_id;
    logic [7:0]  tag;
  } cc_beat1_t;
endpackage

// File: rtl/pio_completer_if.sv
// pio_completer_if: CQ request and CC completion AXI-Stream channels of the PCIe completer port
interface pio_completer_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = C_DATA_WIDTH / 32
);
  logic [C_DATA_WIDTH-1:0] cq_tdata;
  logic [84:0]             cq_tuser;
  logic                    cq_tlast;
  logic [KEEP_WIDTH-1:0]   cq_tkeep;
  logic                    cq_tvalid;
  logic                    cq_tready;
  logic [C_DATA_WIDTH-1:0] cc_tdata;
  logic [32:0]             cc_tuser;
  logic                    cc_tlast;
  logic [KEEP_WIDTH-1:0]   cc_tkeep;
  logic                    cc_tvalid;
  logic                    cc_tready;
  modport master (
    output cq_tdata, cq_tuser, cq_tlast, cq_tkeep, cq_tvalid,
    input  cq_tready,
    input  cc_tdata, cc_tuser, cc_tlast, cc_tkeep, cc_tvalid,
    output cc_tready
  );
  modport slave (
    input  cq_tdata, cq_tuser, cq_tlast, cq_tkeep, cq_tvalid,
    output cq_tready,
    output cc_tdata, cc_tuser, cc_tlast, cc_tkeep, cc_tvalid,
    input  cc_tready
  );
endinterface

// File: rtl/pio_regfile.sv
// pio_regfile: 32-bit register array with byte-enable write port and combinational read port
module pio_regfile #(
  parameter int REG_AW = 4
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [REG_AW-1:0] widx_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  input  logic [REG_AW-1:0] ridx_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**REG_AW];
  assign rdata_o = mem_q[ridx_i];
  // Clear on reset, otherwise merge enabled bytes into the addressed register
  always_ff @(posedge user_clk) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_AW; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) if (be_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end
endmodule

// File: rtl/pio_completer.sv
// pio_completer: PCIe PIO target servicing single-DW MemRd/MemWr against a register file
module pio_completer
  import pcie_pio_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = C_DATA_WIDTH / 32,
  parameter int REG_AW = 4
) (
  input  logic              user_clk,
  input  logic              reset,
  pio_completer_if.slave    bus,
  input  logic [15:0]       completer_id,
  output logic              reg_wr_valid,
  output logic [REG_AW-1:0] reg_wr_idx,
  output logic [31:0]       reg_wr_data,
  output logic [15:0]       drop_count
);
  localparam logic [2:0] IDLE = 3'd0, DESC1 = 3'd1, WR_DATA = 3'd2, CPL0 = 3'd3, CPL1 = 3'd4, DRAIN = 3'd5;
  logic [2:0] state_q, state_d;
  logic [REG_AW-1:0] idx_q;
  logic [4:0] lo_q;
  logic [3:0] be_q;
  logic [15:0] rid_q, drop_q;
  logic [7:0] tag_q;
  logic [2:0] tc_q, attr_q;
  logic wr_valid_q, acc, drop, we, wr_ok, rd_ok, cpl;
  logic [31:0] rd_data;
  cq_desc1_t d1;
  cc_beat0_t b0;
  cc_beat1_t b1;
  logic unused_ok;
  assign d1 = cq_desc1_t'(bus.cq_tdata);
  assign cpl = state_q == CPL0 || state_q == CPL1;
  assign bus.cq_tready = !reset && !cpl;
  assign acc = bus.cq_tvalid && bus.cq_tready;
  assign wr_ok = d1.req_type == 4'(MEM_WR) && d1.dw_count == 11'd1 && !bus.cq_tlast;
  assign rd_ok = d1.req_type == 4'(MEM_RD) && d1.dw_count == 11'd1 && bus.cq_tlast;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_idx = idx_q;
  assign reg_wr_data = rd_data;
  assign drop_count = drop_q;
  assign unused_ok = ^{bus.cq_tkeep, bus.cq_tuser[84:4], bus.cq_tdata};
  pio_regfile #(.REG_AW(REG_AW)) u_regfile (
    .user_clk(user_clk),
    .reset(reset),
    .we_i(we),
    .widx_i(idx_q),
    .be_i(be_q),
    .wdata_i(bus.cq_tdata[31:0]),
    .ridx_i(idx_q),
    .rdata_o(rd_data)
  );
  // Request decode: classify the packet and steer beats until it is consumed or completed
  always_comb begin
    state_d = state_q;
    drop = 1'b0;
    we = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        state_d = bus.cq_tlast ? IDLE : DESC1;
        drop = bus.cq_tlast;
      end
      DESC1: if (acc) begin
        state_d = wr_ok ? WR_DATA : rd_ok ? CPL0 : bus.cq_tlast ? IDLE : DRAIN;
        drop = !wr_ok && !rd_ok;
      end
      WR_DATA: if (acc) begin
        state_d = bus.cq_tlast ? IDLE : DRAIN;
        we = 1'b1;
      end
      DRAIN: state_d = acc && bus.cq_tlast ? IDLE : DRAIN;
      CPL0: state_d = bus.cc_tready ? CPL1 : CPL0;
      CPL1: state_d = bus.cc_tready ? IDLE : CPL1;
      default: state_d = IDLE;
    endcase
  end
  // State, latched descriptor fields, write pulse and saturating drop counter
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      lo_q <= '0;
      be_q <= '0;
      rid_q <= '0;
      tag_q <= '0;
      tc_q <= '0;
      attr_q <= '0;
      drop_q <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_valid_q <= we;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (state_q == IDLE && acc) begin
        idx_q <= bus.cq_tdata[REG_AW+1:2];
        lo_q <= bus.cq_tdata[6:2];
        be_q <= bus.cq_tuser[3:0];
      end
      if (state_q == DESC1 && acc) begin
        rid_q <= d1.requester_id;
        tag_q <= d1.tag;
        tc_q <= d1.tc;
        attr_q <= d1.attr;
      end
    end
  end
  // Completion beats built from latched request fields; stable while the core stalls
  always_comb begin
    b0 = '0;
    b0.lower_addr = {lo_q, 2'b00};
    b0.byte_count = 13'd4;
    b0.dw_count = 11'd1;
    b0.status = CPL_SC;
    b0.requester_id = rid_q;
    b1 = '0;
    b1.tag = tag_q;
    b1.completer_id = completer_id;
    b1.cid_en = 1'b1;
    b1.tc = tc_q;
    b1.attr = attr_q;
    b1.data = rd_data;
    bus.cc_tdata = state_q == CPL0 ? C_DATA_WIDTH'(b0) : state_q == CPL1 ? C_DATA_WIDTH'(b1) : '0;
    bus.cc_tvalid = cpl;
    bus.cc_tlast = state_q == CPL1;
    bus.cc_tkeep = {KEEP_WIDTH{cpl}};
    bus.cc_tuser = '0;
  end
endmodule
